// File: rtl/vga_scanout_if.sv
// Framebuffer read port between the scanout engine and memory.
// master: mem_req/mem_addr out, mem_ack/mem_rdata in; slave is the mirror.
interface vga_scanout_if;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/vga_scanout.sv
// 640x480 VGA scanout of a 160x120 byte framebuffer (4x4 replication).
// Ports: clk, reset_n (async, active-low), mem (framebuffer read port),
// color/hsync/vsync/blank/vblank_pulse (registered video outputs).
// Optional SCANOUT_UNDERRUN_EN adds underrun (sticky) / underrun_clr.
module vga_scanout #(
    parameter int VACT = 480,
    parameter int VFP  = 10,
    parameter int VSW  = 2,
    parameter int VBP  = 33
) (
    input  logic          clk,
    input  logic          reset_n,
    vga_scanout_if.master mem,
    output logic [7:0]    color,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          vblank_pulse
`ifdef SCANOUT_UNDERRUN_EN
    ,
    output logic          underrun,
    input  logic          underrun_clr
`endif
);
    localparam logic [9:0] V_ACT  = 10'(VACT);
    localparam logic [9:0] V_SYNC = 10'(VACT + VFP);
    localparam logic [9:0] V_SEND = 10'(VACT + VFP + VSW - 1);
    localparam logic [9:0] V_LAST = 10'(VACT + VFP + VSW + VBP - 1);

    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [9:0]  next_line;
    logic        h_last;
    logic        v_last;
    logic        active;
    logic        flush;
    logic        start;
    logic [14:0] row;
    logic [14:0] row_base;

    logic [7:0]  fifo [4];
    logic [1:0]  wp;
    logic [1:0]  rp;
    logic [2:0]  cnt;
    logic [7:0]  col;
    logic        fetch_en;
    logic        req;
    logic [14:0] addr;

    logic        pop_slot;
    logic        empty;
    logic        pop;
    logic        push;
    logic [2:0]  cnt_nx;
    logic [7:0]  col_nx;
    logic        en_nx;
    logic        req_nx;

    assign h_last    = hcount == 10'd799;
    assign v_last    = vcount == V_LAST;
    assign active    = (hcount < 10'd640) && (vcount < V_ACT);
    assign next_line = v_last ? 10'd0 : vcount + 10'd1;
    // Every line end flushes; only a following active line re-arms fetch.
    assign flush     = hcount == 10'd640;
    assign start     = flush && (next_line < V_ACT);

    // row*160 = row*128 + row*32
    assign row      = {7'd0, next_line[9:2]};
    assign row_base = (row << 7) + (row << 5);

    assign pop_slot = active && (hcount[1:0] == 2'd3);
    assign empty    = cnt == 3'd0;
    assign pop      = pop_slot && !empty;
    assign push     = req && mem.mem_ack && !flush;

    always_comb begin
        cnt_nx = cnt + {2'd0, push} - {2'd0, pop};
        col_nx = col + {7'd0, push};
        en_nx  = fetch_en;
        if (flush) begin
            cnt_nx = 3'd0;
            col_nx = 8'd0;
            en_nx  = start;
        end
    end

    // Registered request: decided from next-cycle FIFO state so a full
    // FIFO or finished line never sees a request.
    assign req_nx = en_nx && (cnt_nx < 3'd4) && (col_nx < 8'd160);

    assign mem.mem_req  = req;
    assign mem.mem_addr = addr;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wp] <= mem.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount       <= 10'd0;
            vcount       <= 10'd0;
            wp           <= 2'd0;
            rp           <= 2'd0;
            cnt          <= 3'd0;
            col          <= 8'd0;
            fetch_en     <= 1'b1;
            req          <= 1'b0;
            addr         <= 15'd0;
            color        <= 8'd0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            blank        <= 1'b1;
            vblank_pulse <= 1'b0;
        end else begin
            if (h_last) begin
                hcount <= 10'd0;
                vcount <= next_line;
            end else begin
                hcount <= hcount + 10'd1;
            end

            cnt      <= cnt_nx;
            col      <= col_nx;
            fetch_en <= en_nx;
            req      <= req_nx;

            if (flush) begin
                wp   <= 2'd0;
                rp   <= 2'd0;
                addr <= row_base;
            end else begin
                if (push) begin
                    wp <= wp + 2'd1;
                    // Hold on the last byte so addr stays inside the row.
                    if (col != 8'd159) begin
                        addr <= addr + 15'd1;
                    end
                end
                if (pop) begin
                    rp <= rp + 2'd1;
                end
            end

            color        <= (active && !empty) ? fifo[rp] : 8'd0;
            hsync        <= !((hcount >= 10'd656) && (hcount <= 10'd751));
            vsync        <= !((vcount >= V_SYNC) && (vcount <= V_SEND));
            blank        <= !active;
            vblank_pulse <= (hcount == 10'd0) && (vcount == V_ACT);
        end
    end

`ifdef SCANOUT_UNDERRUN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
        end else if (pop_slot && empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end
`endif
endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 The module SHALL have one clock and asynchronous active-low reset: all state clears on reset_n low regardless of clk.
REQ-002 clk  input  1  pixel clock, 25.175 MHz nominal; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 mem_req  output  1  framebuffer read request; held with mem_addr until accepted.
REQ-005 mem_addr  output  15  framebuffer byte address, range 0..19199.
REQ-006 mem_ack  input  1  request accepted this cycle; mem_rdata valid in the same cycle; ignored while mem_req=0.
REQ-007 mem_rdata  input  8  framebuffer byte, a palette index.
REQ-008 color  output  8  palette index for the downstream byte-to-RGB stage; 0 when blank.
REQ-009 hsync, vsync  output  1 each  sync, active-low.
REQ-010 blank  output  1  high outside the 640x480 active area.
REQ-011 vblank_pulse  output  1  one-cycle pulse at the start of vertical blanking.

Function
REQ-012 Counters: hcount 0..799 (640 active, 16 front porch, 96 sync, 48 back porch); vcount 0..524 (480 active, 10 front porch, 2 sync, 33 back porch); hcount wraps 799->0 and advances vcount; vcount wraps 524->0.
REQ-013 color, hsync, vsync, blank and vblank_pulse SHALL all be registered and mutually aligned, each reflecting the counter state of the previous cycle (latency 1).
REQ-014 hsync is low for hcount 656..751; vsync is low for vcount 490..491; blank is high when hcount>=640 or vcount>=480.
REQ-015 vblank_pulse SHALL be high for exactly one cycle, for counter state hcount=0, vcount=480.
REQ-016 Source image: 160x120 bytes, each replicated 4x4; display pixel (x,y) maps to address (y>>2)*160 + (x>>2), computed with shift-add only, no multiplier.
REQ-017 Prefetch FIFO: 4 entries x 8 bits; one byte is popped when hcount[1:0]==3 in the active area; color holds the current byte for its 4 pixels.
REQ-018 Line fetch start: at hcount=640 when the next line is active (vcount<479, or vcount=524 for line 0), flush the FIFO, set fetch column to 0 and set the source row to (next line)>>2.
REQ-019 Fetcher: mem_req=1 while FIFO count<4 and fetch column<160; on mem_req&&mem_ack push mem_rdata and increment both the column and mem_addr; no requests are issued during vertical blanking.
REQ-020 mem_req may be withdrawn without an ack only at a line-fetch-start flush; mem_addr SHALL be stable while mem_req=1 and mem_ack=0.
REQ-021 A push and a pop in the same cycle SHALL leave the count unchanged; a push when full or a pop when empty SHALL never occur from fetch logic; a pop when empty is an underrun (REQ-025).
REQ-022 The FIFO holds 4 bytes before hcount=0 whenever the memory acks within 160 cycles of line fetch start.

Reset
REQ-023 On reset: hcount=0, vcount=0, FIFO empty, fetch column 0, mem_req=0, mem_addr=0, color=0, hsync=1, vsync=1, blank=1, vblank_pulse=0; the first frame starts at line 0 with no prefetch (underrun expected in line 0 if no mem_ack arrives).
REQ-024 A reset asserted mid-line or mid-request SHALL drop mem_req immediately (asynchronously) and discard FIFO contents.

Configuration
REQ-025 Macro SCANOUT_UNDERRUN_EN: when defined, ports underrun (output, 1, sticky) and underrun_clr (input, 1) exist; a pop from an empty FIFO sets underrun and outputs color 0; underrun_clr=1 clears it, and a set in the same cycle wins. When not defined, the ports are absent, and an empty pop outputs color 0 silently.

Verification
REQ-026 Free-run one frame, mem_ack tied to 1 -> hsync low for 96 cycles per line, 525 lines, vsync low for 2 lines (1600 cycles), vblank_pulse exactly once per 420000 cycles.
REQ-027 Memory returning rdata=addr[7:0], ack=1 -> line y=5 shows bytes 160..319 (low 8 bits), each for 4 pixels; mem_addr never exceeds 19199.
REQ-028 mem_ack pulsed every 3rd cycle -> no underrun; FIFO count stays at or below 4; mem_addr is stable during waits.
REQ-029 mem_ack held 0 for a whole line (SCANOUT_UNDERRUN_EN) -> color=0 on that line, underrun=1 until underrun_clr, next line recovers with correct data.
REQ-030 reset_n low at hcount=300, vcount=200 with mem_req high -> mem_req=0 and all outputs at reset values in the same cycle; after release, timing restarts at (0,0).
